// File: rtl/note_sequencer.sv
// Melody playback sequencer: fetches note words, times note/space periods in sample ticks,
// and drives the tone generator. Define NOTE_SEQ_ONESHOT_EN to stop after one pass.
module note_sequencer #(
  parameter int TICK_SAMPLES = 5468,
  parameter int MELODY_LEN   = 212,
  parameter int ADDR_BITS    = 8,
  parameter int NUM_NOTES    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_tick,
  output logic                 rom_req,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic                 rom_valid,
  input  logic [4:0]           rom_data,
  output logic [3:0]           note_out,
  output logic                 gate,
  output logic                 busy,
  output logic                 loop_done
);

  localparam int CNT_BITS = $clog2(7 * TICK_SAMPLES);
  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam cnt_t SHORT_LAST = cnt_t'(3 * TICK_SAMPLES - 1);
  localparam cnt_t LONG_LAST  = cnt_t'(7 * TICK_SAMPLES - 1);
  localparam cnt_t SPACE_LAST = cnt_t'(TICK_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MELODY_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    NOTE,
    SPACE
  } state_t;

  state_t               state, state_nx;
  cnt_t                 cnt, cnt_nx;
  logic                 len_long, len_long_nx;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [3:0]           note_nx;
  logic                 gate_nx, req_nx, busy_nx, loop_done_nx;

  // NOTE: every output is a flop, so the comb block computes next values and the
  // register block only copies them; non-blocking assignments keep all flops
  // updating from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_long  <= 1'b0;
      rom_addr  <= '0;
      note_out  <= '0;
      gate      <= 1'b0;
      rom_req   <= 1'b0;
      busy      <= 1'b0;
      loop_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      len_long  <= len_long_nx;
      rom_addr  <= addr_nx;
      note_out  <= note_nx;
      gate      <= gate_nx;
      rom_req   <= req_nx;
      busy      <= busy_nx;
      loop_done <= loop_done_nx;
    end
  end

  // NOTE: each next value defaults to "hold" before the case statement so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    len_long_nx  = len_long;
    addr_nx      = rom_addr;
    note_nx      = note_out;
    gate_nx      = gate;
    req_nx       = rom_req;
    loop_done_nx = 1'b0;

    if (stop) begin
      // Abort wins over everything, including a fetch completing this cycle.
      state_nx = IDLE;
      cnt_nx   = '0;
      addr_nx  = '0;
      gate_nx  = 1'b0;
      req_nx   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = FETCH;
            addr_nx  = '0;
            cnt_nx   = '0;
            req_nx   = 1'b1;
          end
        end

        FETCH: begin
          req_nx  = 1'b1;
          gate_nx = 1'b0;
          if (rom_valid) begin
            state_nx    = NOTE;
            note_nx     = rom_data[4:1];
            len_long_nx = rom_data[0];
            // Out-of-range codes are rests: timed like a note but silent.
            gate_nx     = (int'(rom_data[4:1]) < NUM_NOTES);
            req_nx      = 1'b0;
            cnt_nx      = '0;
          end
        end

        NOTE: begin
          if (sample_tick) begin
            if (cnt == (len_long ? LONG_LAST : SHORT_LAST)) begin
              state_nx = SPACE;
              cnt_nx   = '0;
              gate_nx  = 1'b0;
            end else begin
              cnt_nx = cnt + cnt_t'(1);
            end
          end
        end

        SPACE: begin
          if (sample_tick) begin
            if (cnt == SPACE_LAST) begin
              cnt_nx = '0;
              if (rom_addr == LAST_ADDR) begin
                addr_nx      = '0;
                loop_done_nx = 1'b1;
`ifdef NOTE_SEQ_ONESHOT_EN
                state_nx     = IDLE;
`else
                state_nx     = FETCH;
                req_nx       = 1'b1;
`endif
              end else begin
                addr_nx  = rom_addr + 1'b1;
                state_nx = FETCH;
                req_nx   = 1'b1;
              end
            end else begin
              cnt_nx = cnt + cnt_t'(1);
            end
          end
        end

        default: begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          gate_nx  = 1'b0;
        end
      endcase
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule
